// File: rtl/pc_unit_pkg.sv
// Shared defines for the PC / fetch-address unit: ROM port ops, widths, defaults.
// Optional macro PC_ALIGN_EN forces word alignment of branch targets and ROM address.
package pc_unit_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ROM_OP_INST = 2'b00,
      ROM_OP_RD   = 2'b01,
      ROM_OP_WR   = 2'b10,
      ROM_OP_INSX = 2'b11
   } rom_op_e;

   localparam logic [ADDR_W-1:0] RESET_PC_DEF   = 32'h8000_0000;
   localparam logic [ADDR_W-1:0] EXC_VECTOR_DEF = 32'h8000_1180;
   localparam logic [ADDR_W-1:0] PC_STEP        = 32'd4;
   localparam logic [ADDR_W-1:0] WORD_MASK      = 32'hFFFF_FFFC;

   // Data read/write steals the ROM port from instruction fetch.
   function automatic logic is_data_op(input logic [1:0] op);
      logic r;
      r = 1'b0;
      case (op)
         ROM_OP_RD: r = 1'b1;
         ROM_OP_WR: r = 1'b1;
         default:   r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_wr_op(input logic [1:0] op);
      return op == ROM_OP_WR;
   endfunction

   // Word alignment is only applied in the aligned build.
   function automatic logic [ADDR_W-1:0] align_addr(
      input logic [ADDR_W-1:0] a
   );
`ifdef PC_ALIGN_EN
      return a & WORD_MASK;
`else
      return a;
`endif
   endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter and ROM port address/data mux for the fetch stage.
// Define PC_ALIGN_EN to force bits [1:0] of branch targets and ROM address to zero.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [5:0]        stall,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_address_i,
   input  logic [1:0]        rom_op_i,
   input  logic [DATA_W-1:0] rom_wr_data_i,
   input  logic [ADDR_W-1:0] rom_rw_addr_i,
   output logic [ADDR_W-1:0] pc_or_addr,
   output logic              ce,
   output logic              rom_op_o,
   output logic [DATA_W-1:0] wr_data_o
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic              ce_q;
   logic              data_acc;
   logic              data_wr;
   logic              unused_stall;

   // Only the PC/IF stage bit of the stall vector matters here.
   assign unused_stall = ^stall[5:1];

   assign data_acc = is_data_op(rom_op_i);
   assign data_wr  = is_wr_op(rom_op_i);

   // Next-pc select: flush > stall > data access > branch > increment.
   always_comb begin
      pc_d = pc_q;
      if (!ce_q) begin
         pc_d = RESET_PC;
      end else if (flush) begin
         pc_d = EXC_VECTOR;
      end else if (stall[0]) begin
         pc_d = pc_q;
      end else if (data_acc) begin
         pc_d = pc_q;
      end else if (branch_flag_i) begin
         pc_d = align_addr(branch_target_address_i);
      end else begin
         pc_d = pc_q + PC_STEP;
      end
   end

   // PC and chip-enable registers; reset restarts fetch at RESET_PC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
         ce_q <= 1'b0;
      end else begin
         pc_q <= pc_d;
         ce_q <= 1'b1;
      end
   end

   // ROM port: data access address overrides the fetch pc.
   always_comb begin
      pc_or_addr = align_addr(pc_q);
      if (data_acc) begin
         pc_or_addr = align_addr(rom_rw_addr_i);
      end
   end

   // Write strobe and data are only live for a data write.
   always_comb begin
      rom_op_o  = data_wr;
      wr_data_o = '0;
      if (data_wr) begin
         wr_data_o = rom_wr_data_i;
      end
   end

   assign ce = ce_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit.
// Expected addresses are queued when stimulus is driven and popped after the edge.
module tb_pc_unit;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [5:0]  stall;
   logic        branch_flag_i;
   logic [31:0] branch_target_address_i;
   logic [1:0]  rom_op_i;
   logic [31:0] rom_wr_data_i;
   logic [31:0] rom_rw_addr_i;
   logic [31:0] pc_or_addr;
   logic        ce;
   logic        rom_op_o;
   logic [31:0] wr_data_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] sb[$];
   logic [31:0] m_pc;
   logic [31:0] exp_v;
   logic [31:0] got_v;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] EXC_PC = 32'h8000_1180;

   pc_unit dut (
      .clk                     (clk),
      .rst                     (rst),
      .flush                   (flush),
      .stall                   (stall),
      .branch_flag_i           (branch_flag_i),
      .branch_target_address_i (branch_target_address_i),
      .rom_op_i                (rom_op_i),
      .rom_wr_data_i           (rom_wr_data_i),
      .rom_rw_addr_i           (rom_rw_addr_i),
      .pc_or_addr              (pc_or_addr),
      .ce                      (ce),
      .rom_op_o                (rom_op_o),
      .wr_data_o               (wr_data_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 1'b0;
      stall = 6'b0;
      branch_flag_i = 1'b0;
      branch_target_address_i = 32'h0;
      rom_op_i = 2'b00;
      rom_wr_data_i = 32'h0;
      rom_rw_addr_i = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      #20;
      checks++;
      if (ce !== 1'b0) begin
         errors++;
         $display("FAIL reset_ce: got %b expected 0", ce);
      end
      checks++;
      if (pc_or_addr !== RST_PC) begin
         errors++;
         $display("FAIL reset_addr: got %h expected %h", pc_or_addr, RST_PC);
      end
      #2 rst = 1'b1;
      m_pc = RST_PC;
      tick();
      checks++;
      if (ce !== 1'b1) begin
         errors++;
         $display("FAIL first_edge_ce: got %b expected 1", ce);
      end
      checks++;
      if (pc_or_addr !== RST_PC) begin
         errors++;
         $display("FAIL first_edge_addr: got %h expected %h", pc_or_addr, RST_PC);
      end
      for (int i = 0; i < 2; i++) begin
         m_pc = m_pc + 32'd4;
         sb.push_back(m_pc);
         tick();
         exp_v = sb.pop_front();
         checks++;
         if (pc_or_addr !== exp_v) begin
            errors++;
            $display("FAIL reset_incr%0d: got %h expected %h", i, pc_or_addr, exp_v);
         end
      end
   endtask

   task automatic test_branch();
      branch_flag_i = 1'b1;
      branch_target_address_i = 32'h8000_0100;
      sb.push_back(32'h8000_0100);
      tick();
      branch_flag_i = 1'b0;
      branch_target_address_i = 32'h1234_5678;
      sb.push_back(32'h8000_0104);
      exp_v = sb.pop_front();
      checks++;
      if (pc_or_addr !== exp_v) begin
         errors++;
         $display("FAIL branch_load: got %h expected %h", pc_or_addr, exp_v);
      end
      tick();
      exp_v = sb.pop_front();
      checks++;
      if (pc_or_addr !== exp_v) begin
         errors++;
         $display("FAIL branch_next: got %h expected %h", pc_or_addr, exp_v);
      end
      m_pc = 32'h8000_0104;
   endtask

   task automatic test_stall();
      stall = 6'b000001;
      branch_flag_i = 1'b1;
      branch_target_address_i = 32'h8000_0400;
      sb.push_back(m_pc);
      tick();
      exp_v = sb.pop_front();
      checks++;
      if (pc_or_addr !== exp_v) begin
         errors++;
         $display("FAIL stall_hold: got %h expected %h", pc_or_addr, exp_v);
      end
      stall = 6'b0;
      branch_flag_i = 1'b0;
      m_pc = m_pc + 32'd4;
      sb.push_back(m_pc);
      tick();
      exp_v = sb.pop_front();
      checks++;
      if (pc_or_addr !== exp_v) begin
         errors++;
         $display("FAIL stall_resume: got %h expected %h", pc_or_addr, exp_v);
      end
      // upper stall bits must not hold the pc
      stall = 6'b111110;
      m_pc = m_pc + 32'd4;
      sb.push_back(m_pc);
      tick();
      stall = 6'b0;
      exp_v = sb.pop_front();
      checks++;
      if (pc_or_addr !== exp_v) begin
         errors++;
         $display("FAIL stall_upper: got %h expected %h", pc_or_addr, exp_v);
      end
   endtask

   task automatic test_data_access();
      rom_op_i = 2'b10;
      rom_rw_addr_i = 32'h8000_2000;
      rom_wr_data_i = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (pc_or_addr !== 32'h8000_2000) begin
         errors++;
         $display("FAIL wr_addr: got %h expected 80002000", pc_or_addr);
      end
      checks++;
      if (rom_op_o !== 1'b1) begin
         errors++;
         $display("FAIL wr_op: got %b expected 1", rom_op_o);
      end
      checks++;
      if (wr_data_o !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL wr_data: got %h expected deadbeef", wr_data_o);
      end
      tick();
      rom_op_i = 2'b01;
      rom_rw_addr_i = 32'h8000_3000;
      #1;
      checks++;
      if (rom_op_o !== 1'b0 || wr_data_o !== 32'h0) begin
         errors++;
         $display("FAIL rd_ctrl: got op %b data %h expected 0 0", rom_op_o, wr_data_o);
      end
      checks++;
      if (pc_or_addr !== 32'h8000_3000) begin
         errors++;
         $display("FAIL rd_addr: got %h expected 80003000", pc_or_addr);
      end
      tick();
      rom_op_i = 2'b00;
      #1;
      checks++;
      if (pc_or_addr !== m_pc) begin
         errors++;
         $display("FAIL data_pc_held: got %h expected %h", pc_or_addr, m_pc);
      end
      // 2'b11 behaves as instruction fetch
      rom_op_i = 2'b11;
      rom_rw_addr_i = 32'h8000_5000;
      m_pc = m_pc + 32'd4;
      sb.push_back(m_pc);
      tick();
      exp_v = sb.pop_front();
      got_v = pc_or_addr;
      rom_op_i = 2'b00;
      checks++;
      if (got_v !== exp_v || rom_op_o !== 1'b0) begin
         errors++;
         $display("FAIL op11_fetch: got %h/%b expected %h/0", got_v, rom_op_o, exp_v);
      end
   endtask

   task automatic test_flush();
      flush = 1'b1;
      stall = 6'b000001;
      branch_flag_i = 1'b1;
      branch_target_address_i = 32'h8000_0100;
      sb.push_back(EXC_PC);
      tick();
      idle_inputs();
      exp_v = sb.pop_front();
      checks++;
      if (pc_or_addr !== exp_v) begin
         errors++;
         $display("FAIL flush_prio: got %h expected %h", pc_or_addr, exp_v);
      end
      m_pc = EXC_PC + 32'd4;
      sb.push_back(m_pc);
      tick();
      exp_v = sb.pop_front();
      checks++;
      if (pc_or_addr !== exp_v) begin
         errors++;
         $display("FAIL flush_next: got %h expected %h", pc_or_addr, exp_v);
      end
   endtask

   task automatic test_wrap();
      branch_flag_i = 1'b1;
      branch_target_address_i = 32'hFFFF_FFFC;
      sb.push_back(32'hFFFF_FFFC);
      sb.push_back(32'h0000_0000);
      tick();
      branch_flag_i = 1'b0;
      exp_v = sb.pop_front();
      checks++;
      if (pc_or_addr !== exp_v) begin
         errors++;
         $display("FAIL wrap_load: got %h expected %h", pc_or_addr, exp_v);
      end
      tick();
      exp_v = sb.pop_front();
      checks++;
      if (pc_or_addr !== exp_v) begin
         errors++;
         $display("FAIL wrap_zero: got %h expected %h", pc_or_addr, exp_v);
      end
      m_pc = 32'h0;
   endtask

   task automatic test_reset_mid();
      branch_flag_i = 1'b1;
      branch_target_address_i = RST_PC;
      tick();
      branch_flag_i = 1'b0;
      m_pc = RST_PC;
      for (int i = 0; i < 4; i++) begin
         m_pc = m_pc + 32'd4;
         sb.push_back(m_pc);
         tick();
         exp_v = sb.pop_front();
         checks++;
         if (pc_or_addr !== exp_v) begin
            errors++;
            $display("FAIL mid_incr%0d: got %h expected %h", i, pc_or_addr, exp_v);
         end
      end
      flush = 1'b1;
      branch_flag_i = 1'b1;
      rst = 1'b0;
      #1;
      checks++;
      if (pc_or_addr !== RST_PC || ce !== 1'b0) begin
         errors++;
         $display("FAIL mid_async: got %h/%b expected %h/0", pc_or_addr, ce, RST_PC);
      end
      #2;
      idle_inputs();
      rst = 1'b1;
      tick();
      m_pc = RST_PC + 32'd4;
      sb.push_back(m_pc);
      tick();
      exp_v = sb.pop_front();
      checks++;
      if (pc_or_addr !== exp_v || ce !== 1'b1) begin
         errors++;
         $display("FAIL mid_restart: got %h/%b expected %h/1", pc_or_addr, ce, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_stall();
      test_data_access();
      test_flush();
      test_wrap();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d left expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
